// File: rtl/uart_rx_os.sv
// UART receiver driven by a 16x (SAMPLE_MULTIPLIER) oversample strobe, with held valid/ack output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_os #(
  parameter int DATA_BITS         = 8,
  parameter int SAMPLE_MULTIPLIER = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ack,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SW = $clog2(SAMPLE_MULTIPLIER);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [SW-1:0] MID      = SW'(SAMPLE_MULTIPLIER / 2 - 1);
  localparam logic [SW-1:0] LAST     = SW'(SAMPLE_MULTIPLIER - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Later assignments in the STOP branch override the ack-driven clear, so a
  // byte completing on an ack cycle keeps dout_valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_ack && dout_valid) begin
        dout_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (rxclk_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state      <= START;
              sample_cnt <= '0;
              busy       <= 1'b1;
            end
          end
          START: begin
            if (sample_cnt == MID) begin
              sample_cnt <= '0;
              bit_idx    <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
          DATA: begin
            if (sample_cnt == LAST) begin
              sample_cnt <= '0;
              shreg      <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_idx    <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sample_cnt == LAST) begin
              sample_cnt <= '0;
              par_bad    <= (^shreg) ^ rx_s;
              state      <= STOP;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (sample_cnt == LAST) begin
              sample_cnt <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
              if (rx_s) begin
                if (!dout_valid || dout_ack) begin
                  dout       <= shreg;
                  dout_valid <= 1'b1;
                  overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  parity_err <= par_bad;
`endif
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: vector table of frames plus hand-written corner sequences.
module tb_uart_rx_os;
  localparam int DB = 8;
  localparam int SM = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxclk_en;
  logic          rx;
  logic [DB-1:0] dout;
  logic          dout_valid;
  logic          dout_ack;
  logic          busy;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  int div      = 1;
  int en_cnt   = 0;
  int ferr_total   = 0;
  int perr_total   = 0;
  int busy_total   = 0;

  uart_rx_os #(.DATA_BITS(DB), .SAMPLE_MULTIPLIER(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxclk_en   (rxclk_en),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ack   (dout_ack),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_cnt >= div - 1) en_cnt <= 0;
    else en_cnt <= en_cnt + 1;
  end
  assign rxclk_en = (en_cnt == 0);

  always @(negedge clk) begin
    if (frame_err) ferr_total++;
    if (busy) busy_total++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_total++;
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       ack_first;
    logic [7:0] exp_dout;
    logic       exp_valid;
    int         exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * SM * div) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input logic par_flip);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_bits(1);
`else
    if (par_flip) rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
    send_body(d, par_flip);
    if (stop_ok) begin
      rx = 1'b1;
      wait_bits(1);
    end else begin
      rx = 1'b0;
      repeat ((SM / 2 + 2) * div) @(negedge clk);
      rx = 1'b1;
      repeat ((SM / 2 - 2) * div) @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    dout_ack = 1'b1;
    @(negedge clk);
    dout_ack = 1'b0;
  endtask

  initial begin
    int  ferr_base;
    int  busy_base;
    int  waited;
    logic done;

    vecs[0] = '{8'hC4, 1'b1, 1'b1, 8'hC4, 1'b1, 0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hC4, 1'b0, 1, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0};

    rst_n = 1'b0;
    rx = 1'b1;
    dout_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(dout_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_flags", int'({frame_err, overrun}), 0);
    rst_n = 1'b1;
    wait_bits(2);

    // 0xA5: busy must fall on the same edge dout_valid rises
    send_body(8'hA5, 1'b0);
    check("a5_busy_in_frame", int'(busy), 1);
    rx = 1'b1;
    done = 1'b0;
    waited = 0;
    while (!done && waited < SM * div + 4) begin
      @(negedge clk);
      waited++;
      if (!busy) done = 1'b1;
    end
    check("a5_busy_fall_timeout", int'(done), 1);
    check("a5_valid_at_busy_fall", int'(dout_valid), 1);
    check("a5_dout", int'(dout), 8'hA5);
    wait_bits(2);
    check("a5_valid_held", int'(dout_valid), 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ack_first) pulse_ack();
      ferr_base = ferr_total;
      send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0);
      wait_bits(2);
      check($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
      check($sformatf("vec%0d_valid", i), int'(dout_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ferr_pulses", i), ferr_total - ferr_base, vecs[i].exp_ferr);
      check($sformatf("vec%0d_overrun", i), int'(overrun), int'(vecs[i].exp_ovr));
    end

    // Short low glitch on the line is rejected at the start-bit mid sample
    pulse_ack();
    ferr_base = ferr_total;
    busy_base = busy_total;
    rx = 1'b0;
    repeat (4 * div) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    check("glitch_busy_bounded", int'((busy_total - busy_base) >= 1 && (busy_total - busy_base) <= 8 * div), 1);
    check("glitch_valid", int'(dout_valid), 0);
    check("glitch_ferr", ferr_total - ferr_base, 0);
    check("glitch_overrun", int'(overrun), 0);

    // Back-to-back frames without ack: second byte lost
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_bits(1);
    check("b2b_dout", int'(dout), 8'h11);
    check("b2b_valid", int'(dout_valid), 1);
    check("b2b_overrun", int'(overrun), 1);
    pulse_ack();
    check("b2b_ack_valid", int'(dout_valid), 0);
    check("b2b_ack_overrun", int'(overrun), 0);

    // Slower strobe, then reset during data bit 3
    div = 4;
    wait_bits(1);
    send_frame(8'h96, 1'b1, 1'b0);
    wait_bits(1);
    check("div4_dout", int'(dout), 8'h96);
    check("div4_valid", int'(dout_valid), 1);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'hC3 >> i);
      wait_bits(1);
    end
    rx = 1'b1;
    repeat (SM / 2 * div) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_dout", int'(dout), 0);
    check("abort_valid", int'(dout_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_flags", int'({frame_err, overrun}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_bits(12);
    check("abort_no_partial", int'(dout_valid), 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_bits(1);
    check("after_reset_dout", int'(dout), 8'h7E);
    check("after_reset_valid", int'(dout_valid), 1);

`ifdef UART_RX_PARITY_EN
    div = 1;
    pulse_ack();
    wait_bits(1);
    ferr_base = perr_total;
    send_frame(8'h01, 1'b1, 1'b1);
    wait_bits(1);
    check("par_bad_dout", int'(dout), 8'h01);
    check("par_bad_valid", int'(dout_valid), 1);
    check("par_bad_pulse", perr_total - ferr_base, 1);
    pulse_ack();
    ferr_base = perr_total;
    send_frame(8'h01, 1'b1, 1'b0);
    wait_bits(1);
    check("par_ok_dout", int'(dout), 8'h01);
    check("par_ok_pulse", perr_total - ferr_base, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
